// File: rtl/axi_master_bridge_pkg.sv
// ---------------------------------------------------------------------------
// axi_master_bridge_pkg
// Shared constants for the arbiter-to-AXI4 master bridge: AXI encodings for
// response, burst type and beat size, and the read/write FSM state codes.
// ---------------------------------------------------------------------------
package axi_master_bridge_pkg;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  // Read FSM
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] R_DONE = 2'd3;

  // Write FSM
  localparam logic [2:0] W_IDLE = 3'd0;
  localparam logic [2:0] W_ADDR = 3'd1;
  localparam logic [2:0] W_DATA = 3'd2;
  localparam logic [2:0] W_ACK  = 3'd3;
  localparam logic [2:0] W_RESP = 3'd4;
  localparam logic [2:0] W_DONE = 3'd5;

  // Anything other than OKAY (EXOKAY is never expected) counts as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_master_bridge_if.sv
// ---------------------------------------------------------------------------
// axi_master_bridge_if
// AXI4 AR/R/AW/W/B channel bundle between the bridge (master modport) and
// the SoC interconnect (slave modport).
// ---------------------------------------------------------------------------
interface axi_master_bridge_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // AR channel
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  // R channel
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  // AW channel
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  // W channel
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  // B channel
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_master_bridge_rd.sv
// ---------------------------------------------------------------------------
// axi_master_bridge_rd
// Read path: turns a held ren/raddr/rlen request into one AR handshake and
// returns one registered rdata_valid pulse per R beat.
// Ports: clk/rst (async active-low), ce_i start enable, arbiter read request,
// rdata_o/rdata_valid_o beat return, err_o single-cycle error strobe, and the
// AR/R channel signals (araddr/arlen/arvalid/arready, rdata/rresp/rlast/
// rvalid/rready).
// ---------------------------------------------------------------------------
module axi_master_bridge_rd
  import axi_master_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              ren_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [7:0]        rlen_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  logic [1:0]        rd_state;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [DATA_W-1:0] rdata_p1;
  logic              vld_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= R_IDLE;
      araddr_q <= '0;
      arlen_q  <= '0;
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      case (rd_state)
        R_IDLE: begin
          if (ce_i && ren_i) begin
            araddr_q <= raddr_i;
            arlen_q  <= rlen_i;
            rd_state <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (arready) rd_state <= R_DATA;
        end
        // R beat -> registered return (stage p1)
        R_DATA: begin
          if (rvalid) begin
            rdata_p1 <= rdata;
            vld_p1   <= 1'b1;
            if (rlast) rd_state <= R_DONE;
          end
        end
        // The arbiter still holds ren while it eats the last pulse, so this
        // state exists only to keep that stale request from restarting.
        R_DONE:  rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign araddr        = araddr_q;
  assign arlen         = arlen_q;
  assign arvalid       = (rd_state == R_ADDR);
  assign rready        = (rd_state == R_DATA);
  assign rdata_o       = rdata_p1;
  assign rdata_valid_o = vld_p1;
  assign err_o         = rvalid && rready && resp_is_err(rresp);

endmodule

// File: rtl/axi_master_bridge_wr.sv
// ---------------------------------------------------------------------------
// axi_master_bridge_wr
// Write path: one AW handshake, then wlen+1 W beats separated by an idle
// cycle so the arbiter can present the next word, then the B response.
// wdata_resp_o pulses after every non-last beat and after B for the last.
// Ports: clk/rst (async active-low), ce_i start enable, arbiter write request
// (wen/waddr/wlen/wsel/wdata), wdata_resp_o beat acknowledge, err_o error
// strobe, and the AW/W/B channel signals.
// ---------------------------------------------------------------------------
module axi_master_bridge_wr
  import axi_master_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce_i,
  input  logic                wen_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [7:0]          wlen_i,
  input  logic [DATA_W/8-1:0] wsel_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                wdata_resp_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  logic [2:0]        wr_state;
  logic [ADDR_W-1:0] awaddr_q;
  logic [7:0]        awlen_q;
  logic [7:0]        beat_q;
  logic              resp_p1;
  logic              last_beat;

  assign last_beat = (beat_q == awlen_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state <= W_IDLE;
      awaddr_q <= '0;
      awlen_q  <= '0;
      beat_q   <= '0;
      resp_p1  <= 1'b0;
    end else begin
      resp_p1 <= 1'b0;
      case (wr_state)
        W_IDLE: begin
          if (ce_i && wen_i) begin
            awaddr_q <= waddr_i;
            awlen_q  <= wlen_i;
            beat_q   <= '0;
            wr_state <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (awready) wr_state <= W_DATA;
        end
        // W beat -> registered acknowledge (stage p1)
        W_DATA: begin
          if (wready) begin
            if (last_beat) begin
              // The final acknowledge waits for B so the arbiter knows the
              // whole burst is committed.
              wr_state <= W_RESP;
            end else begin
              resp_p1  <= 1'b1;
              beat_q   <= beat_q + 8'd1;
              wr_state <= W_ACK;
            end
          end
        end
        // wvalid drops for a cycle while the arbiter advances wdata_i.
        W_ACK:  wr_state <= W_DATA;
        W_RESP: begin
          if (bvalid) begin
            resp_p1  <= 1'b1;
            wr_state <= W_DONE;
          end
        end
        // Swallows the still-held wen after the final acknowledge.
        W_DONE:  wr_state <= W_IDLE;
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  assign awaddr       = awaddr_q;
  assign awlen        = awlen_q;
  assign awvalid      = (wr_state == W_ADDR);
  assign wvalid       = (wr_state == W_DATA);
  assign wdata        = wdata_i;
  assign wstrb        = wsel_i;
  assign wlast        = wvalid && last_beat;
  assign bready       = (wr_state == W_RESP);
  assign wdata_resp_o = resp_p1;
  assign err_o        = bvalid && bready && resp_is_err(bresp);

endmodule

// File: rtl/axi_master_bridge.sv
// ---------------------------------------------------------------------------
// axi_master_bridge
// Converts the cache arbiter's level-held read/write requests into AXI4
// master transactions. Read and write paths are independent and can run
// concurrently; this level wires them to the bus and keeps the sticky error.
// Ports: clk, rst (async active-low), ce_i (blocks new starts only),
// ren_i/raddr_i/rlen_i -> rdata_o/rdata_valid_o,
// wen_i/waddr_i/wlen_i/wsel_i/wdata_i -> wdata_resp_o,
// bus_err_o (sticky until reset), axi (AXI4 master modport).
// ---------------------------------------------------------------------------
module axi_master_bridge
  import axi_master_bridge_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce_i,
  input  logic                ren_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  input  logic [7:0]          rlen_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rdata_valid_o,
  input  logic                wen_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [7:0]          wlen_i,
  input  logic [DATA_W/8-1:0] wsel_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                wdata_resp_o,
  output logic                bus_err_o,
  axi_master_bridge_if.master axi
);

  logic rd_err;
  logic wr_err;
  logic bus_err_q;

  assign axi.arid    = '0;
  assign axi.arsize  = SIZE_4B;
  assign axi.arburst = BURST_INCR;
  assign axi.awid    = '0;
  assign axi.awsize  = SIZE_4B;
  assign axi.awburst = BURST_INCR;

  axi_master_bridge_rd #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rd (
    .clk           (clk),
    .rst           (rst),
    .ce_i          (ce_i),
    .ren_i         (ren_i),
    .raddr_i       (raddr_i),
    .rlen_i        (rlen_i),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .err_o         (rd_err),
    .araddr        (axi.araddr),
    .arlen         (axi.arlen),
    .arvalid       (axi.arvalid),
    .arready       (axi.arready),
    .rdata         (axi.rdata),
    .rresp         (axi.rresp),
    .rlast         (axi.rlast),
    .rvalid        (axi.rvalid),
    .rready        (axi.rready)
  );

  axi_master_bridge_wr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .wen_i        (wen_i),
    .waddr_i      (waddr_i),
    .wlen_i       (wlen_i),
    .wsel_i       (wsel_i),
    .wdata_i      (wdata_i),
    .wdata_resp_o (wdata_resp_o),
    .err_o        (wr_err),
    .awaddr       (axi.awaddr),
    .awlen        (axi.awlen),
    .awvalid      (axi.awvalid),
    .awready      (axi.awready),
    .wdata        (axi.wdata),
    .wstrb        (axi.wstrb),
    .wlast        (axi.wlast),
    .wvalid       (axi.wvalid),
    .wready       (axi.wready),
    .bresp        (axi.bresp),
    .bvalid       (axi.bvalid),
    .bready       (axi.bready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 bus_err_q <= 1'b0;
    else if (rd_err || wr_err) bus_err_q <= 1'b1;
  end

  assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_axi_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi_master_bridge
// Table-driven transactions (read, write, or both started together) with
// per-cycle protocol checks inside the driver tasks, plus hand-written
// sequences for reset, ce_i gating and mid-transaction reset.
// ---------------------------------------------------------------------------
module tb_axi_master_bridge;
  import axi_master_bridge_pkg::*;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce_i = 1'b0;
  logic        ren_i = 1'b0;
  logic [31:0] raddr_i = '0;
  logic [7:0]  rlen_i = '0;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        wen_i = 1'b0;
  logic [31:0] waddr_i = '0;
  logic [7:0]  wlen_i = '0;
  logic [3:0]  wsel_i = '0;
  logic [31:0] wdata_i = '0;
  logic        wdata_resp_o;
  logic        bus_err_o;

  axi_master_bridge_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_master_bridge #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .ce_i          (ce_i),
    .ren_i         (ren_i),
    .raddr_i       (raddr_i),
    .rlen_i        (rlen_i),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .wen_i         (wen_i),
    .waddr_i       (waddr_i),
    .wlen_i        (wlen_i),
    .wsel_i        (wsel_i),
    .wdata_i       (wdata_i),
    .wdata_resp_o  (wdata_resp_o),
    .bus_err_o     (bus_err_o),
    .axi           (bus)
  );

  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_err = 0;
  string tag   = "init";

  // Handshake and pulse counters, sampled on the active edge.
  int ar_hs = 0, aw_hs = 0, rp_cnt = 0, wp_cnt = 0;
  always @(posedge clk) begin
    if (bus.arvalid && bus.arready) ar_hs++;
    if (bus.awvalid && bus.awready) aw_hs++;
    if (rdata_valid_o) rp_cnt++;
    if (wdata_resp_o) wp_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got 0x%08h expected 0x%08h", tag, nm, act, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] l, input int dly,
                         input logic [3:0][31:0] d, input logic [1:0] resp);
    ren_i = 1'b1; raddr_i = a; rlen_i = l;
    @(negedge clk);
    chk("arvalid", bus.arvalid, 1);
    chk("araddr", bus.araddr, a);
    chk("arlen", bus.arlen, l);
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      chk("arvalid_hold", bus.arvalid, 1);
      chk("araddr_hold", bus.araddr, a);
    end
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    chk("arvalid_drop", bus.arvalid, 0);
    chk("rready", bus.rready, 1);
    chk("rvld_idle", rdata_valid_o, 0);
    for (int i = 0; i <= int'(l); i++) begin
      bus.rvalid = 1'b1; bus.rdata = d[i]; bus.rlast = (i == int'(l)); bus.rresp = resp;
      @(negedge clk);
      chk("rvld_pulse", rdata_valid_o, 1);
      chk("rdata_o", rdata_o, d[i]);
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = RESP_OKAY;
    @(negedge clk);
    chk("rvld_end", rdata_valid_o, 0);
    chk("no_rearm", bus.arvalid, 0);
    ren_i = 1'b0;
    @(negedge clk);
    chk("no_second_ar", bus.arvalid, 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] l, input logic [3:0] sel,
                          input logic [3:0][31:0] d, input int bdly, input logic [1:0] resp);
    int stall;
    wen_i = 1'b1; waddr_i = a; wlen_i = l; wsel_i = sel; wdata_i = d[0];
    @(negedge clk);
    chk("awvalid", bus.awvalid, 1);
    chk("awaddr", bus.awaddr, a);
    chk("awlen", bus.awlen, l);
    chk("w_before_aw", bus.wvalid, 0);
    bus.awready = 1'b1;
    @(negedge clk);
    bus.awready = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      stall = $urandom_range(0, 2);
      for (int k = 0; k < stall; k++) begin
        chk("wvalid_stall", bus.wvalid, 1);
        chk("wdata_stall", bus.wdata, d[i]);
        @(negedge clk);
      end
      chk("wvalid", bus.wvalid, 1);
      chk("wlast", bus.wlast, (i == int'(l)));
      chk("wdata", bus.wdata, d[i]);
      chk("wstrb", bus.wstrb, sel);
      bus.wready = 1'b1;
      @(negedge clk);
      bus.wready = 1'b0;
      chk("wvalid_gap", bus.wvalid, 0);
      if (i < int'(l)) begin
        chk("wresp_beat", wdata_resp_o, 1);
        wdata_i = d[i+1];
        @(negedge clk);
      end else begin
        chk("wresp_early", wdata_resp_o, 0);
        chk("bready", bus.bready, 1);
      end
    end
    for (int k = 0; k < bdly; k++) begin
      @(negedge clk);
      chk("bready_hold", bus.bready, 1);
      chk("wresp_wait", wdata_resp_o, 0);
    end
    bus.bvalid = 1'b1; bus.bresp = resp;
    @(negedge clk);
    bus.bvalid = 1'b0; bus.bresp = RESP_OKAY;
    chk("wresp_final", wdata_resp_o, 1);
    chk("bready_drop", bus.bready, 0);
    @(negedge clk);
    chk("wresp_end", wdata_resp_o, 0);
    chk("no_rearm_aw", bus.awvalid, 0);
    wen_i = 1'b0;
    @(negedge clk);
    chk("no_second_aw", bus.awvalid, 0);
  endtask

  typedef struct {
    bit              do_rd;
    bit              do_wr;
    logic [31:0]     raddr;
    logic [7:0]      rlen;
    int              ar_dly;
    logic [3:0][31:0] rd;
    logic [1:0]      rresp;
    logic [31:0]     waddr;
    logic [7:0]      wlen;
    logic [3:0]      wsel;
    logic [3:0][31:0] wd;
    int              b_dly;
    logic [1:0]      bresp;
    int              exp_rp;
    int              exp_wp;
    bit              exp_err;
  } vec_t;

  vec_t tbl [6];
  int   ar0, aw0, rp0, wp0;

  initial begin
    bus.arready = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0;
    bus.rvalid = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0; bus.bid = '0;
    bus.bresp = '0; bus.bvalid = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 32'h1C00_0004, 8'd0, 2, {96'h0, 32'hDEAD_BEEF}, 2'b00,
               32'h0, 8'd0, 4'h0, 128'h0, 0, 2'b00, 1, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'h1C00_0040, 8'd3, 0,
               {32'h44, 32'h33, 32'h22, 32'h11}, 2'b00,
               32'h0, 8'd0, 4'h0, 128'h0, 0, 2'b00, 4, 0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'h0, 8'd0, 0, 128'h0, 2'b00,
               32'h2000_0010, 8'd3, 4'hF,
               {32'hA4A4_0004, 32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001}, 3, 2'b00,
               0, 4, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 32'h0, 8'd0, 0, 128'h0, 2'b00,
               32'h3000_0004, 8'd0, 4'b0010, {96'h0, 32'h0000_5A00}, 1, 2'b00,
               0, 1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 32'h1000_0100, 8'd0, 1, {96'h0, 32'hCAFE_F00D}, 2'b00,
               32'h2000_0100, 8'd1, 4'hF, {64'h0, 32'hB2B2_0002, 32'hB1B1_0001}, 2, 2'b10,
               1, 2, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 32'h1000_0200, 8'd3, 0,
               {32'h0D0D_0004, 32'h0C0C_0003, 32'h0B0B_0002, 32'h0A0A_0001}, 2'b00,
               32'h0, 8'd0, 4'h0, 128'h0, 0, 2'b00, 4, 0, 1'b1};

    // Reset state
    tag = "reset";
    #1;
    chk("arvalid", bus.arvalid, 0);
    chk("rready", bus.rready, 0);
    chk("awvalid", bus.awvalid, 0);
    chk("wvalid", bus.wvalid, 0);
    chk("bready", bus.bready, 0);
    chk("rdata_valid", rdata_valid_o, 0);
    chk("wdata_resp", wdata_resp_o, 0);
    chk("bus_err", bus_err_o, 0);
    chk("rdata_o", rdata_o, 0);
    chk("araddr", bus.araddr, 0);
    chk("awlen", bus.awlen, 0);
    chk("arsize", bus.arsize, 3'b010);
    chk("awburst", bus.awburst, 2'b01);
    chk("arid", bus.arid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // ce_i low must block a start
    tag = "ce_low";
    ren_i = 1'b1; wen_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("arvalid", bus.arvalid, 0);
      chk("awvalid", bus.awvalid, 0);
    end
    ren_i = 1'b0; wen_i = 1'b0;
    ce_i = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      tag = $sformatf("vec%0d", t);
      ar0 = ar_hs; aw0 = aw_hs; rp0 = rp_cnt; wp0 = wp_cnt;
      if (tbl[t].do_rd && tbl[t].do_wr) begin
        fork
          do_read(tbl[t].raddr, tbl[t].rlen, tbl[t].ar_dly, tbl[t].rd, tbl[t].rresp);
          do_write(tbl[t].waddr, tbl[t].wlen, tbl[t].wsel, tbl[t].wd, tbl[t].b_dly, tbl[t].bresp);
        join
      end else if (tbl[t].do_rd) begin
        do_read(tbl[t].raddr, tbl[t].rlen, tbl[t].ar_dly, tbl[t].rd, tbl[t].rresp);
      end else begin
        do_write(tbl[t].waddr, tbl[t].wlen, tbl[t].wsel, tbl[t].wd, tbl[t].b_dly, tbl[t].bresp);
      end
      @(negedge clk);
      chk("ar_count", ar_hs - ar0, tbl[t].do_rd ? 1 : 0);
      chk("aw_count", aw_hs - aw0, tbl[t].do_wr ? 1 : 0);
      chk("rd_pulses", rp_cnt - rp0, tbl[t].exp_rp);
      chk("wr_pulses", wp_cnt - wp0, tbl[t].exp_wp);
      chk("bus_err", bus_err_o, tbl[t].exp_err);
    end

    // Reset while both paths are mid-burst
    tag = "mid_reset";
    ren_i = 1'b1; raddr_i = 32'h4000_0000; rlen_i = 8'd3;
    wen_i = 1'b1; waddr_i = 32'h5000_0000; wlen_i = 8'd3; wsel_i = 4'hF; wdata_i = 32'h1234_5678;
    @(negedge clk);
    bus.arready = 1'b1; bus.awready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0; bus.awready = 1'b0;
    chk("rready_pre", bus.rready, 1);
    chk("wvalid_pre", bus.wvalid, 1);
    chk("bus_err_pre", bus_err_o, 1);
    #2 rst = 1'b0;
    #1;
    chk("rready", bus.rready, 0);
    chk("wvalid", bus.wvalid, 0);
    chk("wlast", bus.wlast, 0);
    chk("arvalid", bus.arvalid, 0);
    chk("awvalid", bus.awvalid, 0);
    chk("bready", bus.bready, 0);
    chk("bus_err", bus_err_o, 0);
    chk("araddr", bus.araddr, 0);
    chk("awaddr", bus.awaddr, 0);
    ren_i = 1'b0; wen_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ar", bus.arvalid, 0);
    chk("idle_aw", bus.awvalid, 0);
    tag = "post_reset";
    rp0 = rp_cnt; wp0 = wp_cnt;
    do_read(32'h6000_0008, 8'd0, 0, {96'h0, 32'h600D_DA7A}, 2'b00);
    do_write(32'h7000_000C, 8'd0, 4'b1000, {96'h0, 32'h7700_0000}, 0, 2'b00);
    @(negedge clk);
    chk("rd_pulses", rp_cnt - rp0, 1);
    chk("wr_pulses", wp_cnt - wp0, 1);
    chk("bus_err", bus_err_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_master_bridge.md
Name: axi_master_bridge

Overview:
Sits directly downstream of the cache-to-bus arbiter and drives the SoC AXI4 bus. It converts the arbiter's simplified level-held request interface (ren/raddr/rlen, wen/waddr/wlen/wsel/wdata) into spec-compliant AR/R/AW/W/B channel handshakes. It returns one rdata_valid pulse per read beat and one wdata_resp pulse per write beat, which is what the arbiter's beat counters consume. The read and write paths are independent FSMs and may run concurrently.

Parameters:
ID_W, 4, AXI ID width; all IDs are driven as 0.
ADDR_W, 32, address width.
DATA_W, 32, data width; burst size is fixed at 4 bytes.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
ce_i  input  1  bridge enable; when low, no new transaction starts.
ren_i / raddr_i / rlen_i  input  1/32/8  read request (held), byte address, AXI LEN (0 or 3).
rdata_o / rdata_valid_o  output  32/1  read beat data and per-beat valid pulse.
wen_i / waddr_i / wlen_i / wsel_i  input  1/32/8/4  write request (held), address, LEN, byte strobes.
wdata_i  input  32  current write word; it changes only after a wdata_resp_o pulse.
wdata_resp_o  output  1  per-beat write acknowledge pulse.
bus_err_o  output  1  sticky flag; set on any RRESP/BRESP != OKAY.
arid/araddr/arlen/arsize/arburst/arvalid  output  ID_W/32/8/3/2/1  AR channel.
arready  input  1.
rid/rdata/rresp/rlast/rvalid  input  ID_W/32/2/1/1  R channel.
rready  output  1.
awid/awaddr/awlen/awsize/awburst/awvalid  output  ID_W/32/8/3/2/1  AW channel.
awready  input  1.
wdata/wstrb/wlast/wvalid  output  32/4/1/1  W channel.
wready  input  1.
bid/bresp/bvalid  input  ID_W/2/1  B channel.
bready  output  1.

Behaviour:
- Reset (rst=0, async): both FSMs go to IDLE. All valid/ready outputs, rdata_valid_o, wdata_resp_o and bus_err_o are 0; rdata_o is 0; latched addr/len are 0.
- Constant outputs: arsize = awsize = 3'b010; arburst = awburst = 2'b01 (INCR); arid = awid = 0.
- Read FSM: R_IDLE, R_ADDR, R_DATA, R_DONE.
  - R_IDLE: if ce_i & ren_i, latch raddr_i/rlen_i into araddr/arlen, then go to R_ADDR.
  - R_ADDR: arvalid=1, address held stable; on arready go to R_DATA. Same-cycle arready is allowed, so AR takes a minimum of 1 cycle.
  - R_DATA: rready=1. Each rvalid beat registers rdata_o<=rdata and rdata_valid_o<=1, so the pulse appears 1 cycle after the beat; back-to-back beats give back-to-back pulses. On rvalid&rlast go to R_DONE.
  - R_DONE: exactly one cycle and ren_i is ignored, because the arbiter still holds ren while it consumes the last pulse. Then return to R_IDLE.
- Write FSM: W_IDLE, W_ADDR, W_DATA, W_ACK, W_RESP, W_DONE.
  - W_IDLE: if ce_i & wen_i, latch waddr_i/wlen_i, clear the beat counter, then go to W_ADDR.
  - W_ADDR: awvalid=1; on awready go to W_DATA.
  - W_DATA: wvalid=1, wdata=wdata_i, wstrb=wsel_i, wlast=(beat==awlen).
  - On wready with a non-last beat: register wdata_resp_o=1, increment beat, go to W_ACK.
  - W_ACK: one cycle, wvalid=0, so the arbiter can advance its word; then back to W_DATA.
  - On wready with the last beat: go to W_RESP.
  - W_RESP: bready=1; on bvalid, register wdata_resp_o=1 and go to W_DONE.
  - W_DONE: one cycle, wen_i is ignored; then W_IDLE.
  - Total pulses = wlen+1; the last pulse means the B response has been received.
- AW completes before W starts; W never precedes AW.
- The beat counter is 8 bits and compares equal to awlen; it has no wrap concern for LEN<=255.
- rdata_valid_o and wdata_resp_o are single-cycle pulses, never held.
- bus_err_o is set on rvalid&rready&(rresp!=0) or bvalid&bready&(bresp!=0). It is cleared only by reset. Data is still forwarded normally.
- ce_i deasserted mid-transaction: the current burst completes; only new starts are blocked.
- Simultaneous read and write requests: both FSMs start in the same cycle; there is no interaction.

Decomposition:
- Shared package (axi_pkg): RESP_OKAY, BURST_INCR, SIZE_4B, and the read/write FSM state encodings.
- Natural sub-modules: none needed. Optionally split into axi_rd_ch and axi_wr_ch, one per FSM; the top level only wires them.

Test Plan:
1. Single read: raddr=0x1C00_0004, rlen=0, arready delayed 2 cycles, then rdata=0xDEADBEEF with rlast -> exactly one araddr=0x1C00_0004/arlen=0 handshake; rdata_valid_o pulses once, 1 cycle after the beat, with rdata_o=0xDEADBEEF.
2. 4-beat read: rlen=3, data 0x11,0x22,0x33,0x44 back-to-back, ren held through R_DONE -> 4 consecutive pulses in order; no second AR issued.
3. 4-beat write: wlen=3, wready random, bvalid 3 cycles after the last beat -> wlast only on beat 3; 4 wdata_resp_o pulses, the 4th one cycle after bvalid; wdata matches wdata_i at each beat.
4. Uncached write: wsel=4'b0010, wlen=0 -> wstrb=0010, wlast=1 on the single beat; one resp pulse after B.
5. Concurrent read and write started the same cycle, and bresp=2'b10 -> both complete independently; bus_err_o=1 and stays set until reset.
6. Reset (rst=0) asserted in W_DATA and in R_DATA -> all valids/readies drop immediately; after release both FSMs are idle and a new request works.
